// File: rtl/filter_spad_pkg.sv
// Shared types, defaults and helpers for the ping-pong filter scratchpad.
package filter_spad_pkg;

  typedef enum logic [1:0] {
    FREE  = 2'd0,
    FILL  = 2'd1,
    READY = 2'd2
  } bank_state_t;

  localparam int DEF_DATA_WIDTH = 16;
  localparam int DEF_BANK_DEPTH = 224;

  // A fill depth of zero or beyond the bank size means "use the whole bank".
  function automatic int clamp_depth(input int d, input int max_d);
    return (d == 0 || d > max_d) ? max_d : d;
  endfunction

endpackage

// File: rtl/filter_spad_pingpong_bank.sv
// One scratchpad bank: single write port, registered read port, both on negedge clk.
// Only the read register is reset; RAM contents survive reset.
module spad_bank
  import filter_spad_pkg::*;
#(
  parameter int DATA_WIDTH = DEF_DATA_WIDTH,
  parameter int BANK_DEPTH = DEF_BANK_DEPTH,
  parameter int ADDR_WIDTH = $clog2(BANK_DEPTH)
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic                  i_we,
  input  logic [ADDR_WIDTH-1:0] i_waddr,
  input  logic [DATA_WIDTH-1:0] i_wdata,
  input  logic                  i_re,
  input  logic [ADDR_WIDTH-1:0] i_raddr,
  output logic [DATA_WIDTH-1:0] o_rdata
);

  logic [DATA_WIDTH-1:0] r_mem [BANK_DEPTH];
  logic [DATA_WIDTH-1:0] r_rdata;

  // RAM write port
  always_ff @(negedge clk) begin
    if (i_we) r_mem[i_waddr] <= i_wdata;
  end

  // Registered read port; holds its value when not reading
  always_ff @(negedge clk or negedge reset_n) begin
    if (!reset_n)  r_rdata <= '0;
    else if (i_re) r_rdata <= r_mem[i_raddr];
  end

  assign o_rdata = r_rdata;

endmodule

// File: rtl/filter_spad_pingpong.sv
// Ping-pong filter scratchpad: GLB fills one bank while the PE reads the other.
// Optional macro FILTER_SPAD_RANGE_CHK_EN adds rd_err and zeroes out-of-range reads.
// All state moves on negedge clk so the PE can sample on posedge.
module filter_spad_pingpong
  import filter_spad_pkg::*;
#(
  parameter int DATA_WIDTH = DEF_DATA_WIDTH,
  parameter int BANK_DEPTH = DEF_BANK_DEPTH,
  parameter int ADDR_WIDTH = $clog2(BANK_DEPTH)
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic [ADDR_WIDTH:0]   spad_depth,
  input  logic                  w_valid,
  output logic                  w_ready,
  input  logic [DATA_WIDTH-1:0] din,
  input  logic                  r_en,
  input  logic [ADDR_WIDTH-1:0] r_addr,
  input  logic                  rd_release,
  output logic                  rd_avail,
  output logic [DATA_WIDTH-1:0] dout,
  output logic                  dout_valid,
  output logic                  full,
  output logic                  empty,
  output logic [ADDR_WIDTH:0]   fill_count
`ifdef FILTER_SPAD_RANGE_CHK_EN
  ,
  output logic                  rd_err
`endif
);

  localparam int DW = ADDR_WIDTH + 1;

  bank_state_t           r_state    [2];
  bank_state_t           w_state_nxt[2];
  logic [DW-1:0]         r_depth    [2];
  logic                  r_wb, r_rb, r_rsel, r_dvld;
  logic [DW-1:0]         r_fill_cnt;
  logic [DW-1:0]         w_clamped, w_cur_depth;
  logic                  w_accept, w_fill_done, w_rel, w_rd_fire;
  logic [1:0][DATA_WIDTH-1:0] w_rdata;

  assign w_ready     = (r_state[r_wb] != READY);
  assign rd_avail    = (r_state[r_rb] == READY);
  assign full        = (r_state[0] == READY) && (r_state[1] == READY);
  assign empty       = (r_state[0] == FREE)  && (r_state[1] == FREE);
  assign fill_count  = r_fill_cnt;

  assign w_accept    = w_valid & w_ready;
  assign w_clamped   = DW'(clamp_depth(32'(spad_depth), BANK_DEPTH));
  // A FREE bank takes the live depth on its first word; a filling bank keeps its latch.
  assign w_cur_depth = (r_state[r_wb] == FREE) ? w_clamped : r_depth[r_wb];
  assign w_fill_done = w_accept && ((r_fill_cnt + DW'(1)) == w_cur_depth);
  assign w_rel       = rd_release & rd_avail;
  assign w_rd_fire   = r_en & rd_avail;

  // Next bank states: write and release never hit the same bank (one needs READY, the other not)
  always_comb begin
    w_state_nxt = r_state;
    if (w_accept) w_state_nxt[r_wb] = w_fill_done ? READY : FILL;
    if (w_rel)    w_state_nxt[r_rb] = FREE;
  end

  // Bank states, pointers and fill counter
  always_ff @(negedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state[0] <= FREE;
      r_state[1] <= FREE;
      r_wb       <= 1'b0;
      r_rb       <= 1'b0;
      r_fill_cnt <= '0;
    end else begin
      r_state <= w_state_nxt;
      if (w_accept)    r_fill_cnt <= w_fill_done ? '0 : r_fill_cnt + DW'(1);
      if (w_fill_done) r_wb <= ~r_wb;
      if (w_rel)       r_rb <= ~r_rb;
    end
  end

  // Per-bank depth latch, captured on the first word into a FREE bank
  always_ff @(negedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_depth[0] <= DW'(BANK_DEPTH);
      r_depth[1] <= DW'(BANK_DEPTH);
    end else if (w_accept && r_state[r_wb] == FREE) begin
      r_depth[r_wb] <= w_clamped;
    end
  end

  for (genvar gi = 0; gi < 2; gi++) begin : g_bank
    spad_bank #(
      .DATA_WIDTH(DATA_WIDTH),
      .BANK_DEPTH(BANK_DEPTH),
      .ADDR_WIDTH(ADDR_WIDTH)
    ) u_bank (
      .clk    (clk),
      .reset_n(reset_n),
      .i_we   (w_accept && (r_wb == 1'(gi))),
      .i_waddr(r_fill_cnt[ADDR_WIDTH-1:0]),
      .i_wdata(din),
      .i_re   (w_rd_fire && (r_rb == 1'(gi))),
      .i_raddr(r_addr),
      .o_rdata(w_rdata[gi])
    );
  end

`ifdef FILTER_SPAD_RANGE_CHK_EN
  logic r_zero, r_rd_err, w_oor;
  assign w_oor = ({1'b0, r_addr} >= r_depth[r_rb]);

  // Read bookkeeping: source bank of dout, valid pulse, out-of-range zeroing and error
  always_ff @(negedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_rsel   <= 1'b0;
      r_dvld   <= 1'b0;
      r_zero   <= 1'b0;
      r_rd_err <= 1'b0;
    end else begin
      r_dvld   <= w_rd_fire;
      r_rd_err <= w_rd_fire & w_oor;
      if (w_rd_fire) begin
        r_rsel <= r_rb;
        r_zero <= w_oor;
      end
    end
  end

  assign dout   = r_zero ? '0 : w_rdata[r_rsel];
  assign rd_err = r_rd_err;
`else
  // Read bookkeeping: source bank of dout and valid pulse
  always_ff @(negedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_rsel <= 1'b0;
      r_dvld <= 1'b0;
    end else begin
      r_dvld <= w_rd_fire;
      if (w_rd_fire) r_rsel <= r_rb;
    end
  end

  assign dout = w_rdata[r_rsel];
`endif

  assign dout_valid = r_dvld;

endmodule

// File: tb/tb_filter_spad_pingpong.sv
// Directed bench for filter_spad_pingpong: vector table for fill/read/swap flow,
// hand sequences for async reset, depth latch/clamp and out-of-range read.
module tb_filter_spad_pingpong;

  logic        clk = 1'b0;
  logic        reset_n;
  logic [8:0]  spad_depth;
  logic        w_valid, w_ready;
  logic [15:0] din;
  logic        r_en;
  logic [7:0]  r_addr;
  logic        rd_release, rd_avail;
  logic [15:0] dout;
  logic        dout_valid, full, empty;
  logic [8:0]  fill_count;
`ifdef FILTER_SPAD_RANGE_CHK_EN
  logic        rd_err;
`endif

  int n_tot = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  filter_spad_pingpong dut (
    .clk(clk), .reset_n(reset_n), .spad_depth(spad_depth),
    .w_valid(w_valid), .w_ready(w_ready), .din(din),
    .r_en(r_en), .r_addr(r_addr), .rd_release(rd_release),
    .rd_avail(rd_avail), .dout(dout), .dout_valid(dout_valid),
    .full(full), .empty(empty), .fill_count(fill_count)
`ifdef FILTER_SPAD_RANGE_CHK_EN
    , .rd_err(rd_err)
`endif
  );

  typedef struct {
    logic        wv;
    logic [15:0] d;
    logic        re;
    logic [7:0]  ra;
    logic        rel;
    logic        ewr, eav;
    logic [15:0] edo;
    logic        edv, efull, eempty;
    logic [8:0]  efill;
  } vec_t;

  vec_t tv[25];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_tot++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d want %0d at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic chk_all(input string nm, input logic ewr, input logic eav,
                         input logic [15:0] edo, input logic edv, input logic efull,
                         input logic eempty, input logic [8:0] efill);
    chk({nm, ".w_ready"},    32'(w_ready),    32'(ewr));
    chk({nm, ".rd_avail"},   32'(rd_avail),   32'(eav));
    chk({nm, ".dout"},       32'(dout),       32'(edo));
    chk({nm, ".dout_valid"}, 32'(dout_valid), 32'(edv));
    chk({nm, ".full"},       32'(full),       32'(efull));
    chk({nm, ".empty"},      32'(empty),      32'(eempty));
    chk({nm, ".fill_count"}, 32'(fill_count), 32'(efill));
  endtask

  // Apply inputs, let one negedge pass, settle away from the edge
  task automatic step(input logic wv, input logic [15:0] d, input logic re,
                      input logic [7:0] ra, input logic rel);
    w_valid = wv; din = d; r_en = re; r_addr = ra; rd_release = rel;
    @(negedge clk);
    #2;
    w_valid = 1'b0; r_en = 1'b0; rd_release = 1'b0;
  endtask

  initial begin
    //        wv  din re ra rel  wr av dout dv fu em fill
    tv[0]  = '{1,  1, 0, 0, 0,  1, 0,  0, 0, 0, 0, 1};
    tv[1]  = '{1,  2, 0, 0, 0,  1, 0,  0, 0, 0, 0, 2};
    tv[2]  = '{1,  3, 0, 0, 0,  1, 0,  0, 0, 0, 0, 3};
    tv[3]  = '{1,  4, 0, 0, 0,  1, 1,  0, 0, 0, 0, 0};
    tv[4]  = '{0,  0, 1, 2, 0,  1, 1,  3, 1, 0, 0, 0};
    tv[5]  = '{0,  0, 0, 0, 0,  1, 1,  3, 0, 0, 0, 0};
    tv[6]  = '{1,  5, 0, 0, 0,  1, 1,  3, 0, 0, 0, 1};
    tv[7]  = '{1,  6, 1, 0, 0,  1, 1,  1, 1, 0, 0, 2};
    tv[8]  = '{1,  7, 0, 0, 0,  1, 1,  1, 0, 0, 0, 3};
    tv[9]  = '{1,  8, 0, 0, 0,  0, 1,  1, 0, 1, 0, 0};
    tv[10] = '{1,  9, 1, 3, 0,  0, 1,  4, 1, 1, 0, 0};
    tv[11] = '{1,  9, 1, 0, 0,  0, 1,  1, 1, 1, 0, 0};
    tv[12] = '{1,  9, 0, 0, 1,  1, 1,  1, 0, 0, 0, 0};
    tv[13] = '{1,  9, 1, 0, 0,  1, 1,  5, 1, 0, 0, 1};
    tv[14] = '{1, 10, 1, 3, 0,  1, 1,  8, 1, 0, 0, 2};
    tv[15] = '{1, 11, 1, 1, 0,  1, 1,  6, 1, 0, 0, 3};
    tv[16] = '{1, 12, 1, 2, 0,  0, 1,  7, 1, 1, 0, 0};
    tv[17] = '{0,  0, 0, 0, 1,  1, 1,  7, 0, 0, 0, 0};
    tv[18] = '{1, 13, 1, 0, 0,  1, 1,  9, 1, 0, 0, 1};
    tv[19] = '{1, 14, 1, 3, 0,  1, 1, 12, 1, 0, 0, 2};
    tv[20] = '{1, 15, 0, 0, 0,  1, 1, 12, 0, 0, 0, 3};
    tv[21] = '{1, 16, 0, 0, 1,  1, 1, 12, 0, 0, 0, 0};
    tv[22] = '{0,  0, 1, 1, 0,  1, 1, 14, 1, 0, 0, 0};
    tv[23] = '{0,  0, 0, 0, 1,  1, 0, 14, 0, 0, 1, 0};
    tv[24] = '{0,  0, 1, 0, 0,  1, 0, 14, 0, 0, 1, 0};

    reset_n = 1'b0; spad_depth = 9'd4;
    w_valid = 1'b0; din = '0; r_en = 1'b0; r_addr = '0; rd_release = 1'b0;
    repeat (2) @(negedge clk);
    #2 reset_n = 1'b1;
    chk_all("reset", 1, 0, 0, 0, 0, 1, 0);

    // Fill, read, full stall, release/refill, simultaneous completion + release
    for (int i = 0; i < 25; i++) begin
      step(tv[i].wv, tv[i].d, tv[i].re, tv[i].ra, tv[i].rel);
      chk_all($sformatf("vec%0d", i), tv[i].ewr, tv[i].eav, tv[i].edo,
              tv[i].edv, tv[i].efull, tv[i].eempty, tv[i].efill);
    end

    // Async reset mid-fill: outputs drop immediately, partial fill discarded
    step(1, 21, 0, 0, 0);
    step(1, 22, 0, 0, 0);
    chk("midfill.fill_count", 32'(fill_count), 2);
    #1 reset_n = 1'b0;
    #1 chk_all("async_rst", 1, 0, 0, 0, 0, 1, 0);
    @(negedge clk); #2 reset_n = 1'b1;
    step(1, 31, 0, 0, 0);
    step(1, 32, 0, 0, 0);
    step(1, 33, 0, 0, 0);
    chk("refill3.rd_avail", 32'(rd_avail), 0);
    step(1, 34, 0, 0, 0);
    chk("refill4.rd_avail", 32'(rd_avail), 1);
    step(0, 0, 1, 0, 0);
    chk("refill.dout", 32'(dout), 31);

    // Depth latched at first write; a later change is ignored for this fill
    spad_depth = 9'd2;
    step(1, 41, 0, 0, 0);
    spad_depth = 9'd4;
    step(1, 42, 0, 0, 0);
    chk_all("depth_latch", 0, 1, 31, 0, 1, 0, 0);
    step(0, 0, 0, 0, 1);
    step(0, 0, 1, 1, 0);
    chk("depth_latch.dout", 32'(dout), 42);
    step(0, 0, 0, 0, 1);
    chk("depth_latch.empty", 32'(empty), 1);

    // Depth 0 clamps to the full bank
    spad_depth = 9'd0;
    for (int i = 0; i < 223; i++) step(1, 16'(1000 + i), 0, 0, 0);
    chk_all("clamp223", 1, 0, 42, 0, 0, 0, 223);
    step(1, 1223, 0, 0, 0);
    chk_all("clamp224", 1, 1, 42, 0, 0, 0, 0);
    step(0, 0, 1, 223, 0);
    chk("clamp.dout223", 32'(dout), 1223);
    step(0, 0, 0, 0, 1);
    spad_depth = 9'd4;
    for (int i = 0; i < 4; i++) step(1, 16'(51 + i), 0, 0, 0);
    step(0, 0, 0, 0, 1);
    for (int i = 0; i < 4; i++) step(1, 16'(61 + i), 0, 0, 0);
    chk("oor_setup.rd_avail", 32'(rd_avail), 1);

    // Read beyond the latched depth of 4
    step(0, 0, 1, 5, 0);
    chk("oor.dout_valid", 32'(dout_valid), 1);
`ifdef FILTER_SPAD_RANGE_CHK_EN
    chk("oor.dout", 32'(dout), 0);
    chk("oor.rd_err", 32'(rd_err), 1);
`else
    chk("oor.dout_stale", 32'(dout), 1005);
`endif
    step(0, 0, 1, 1, 0);
    chk("inrange.dout", 32'(dout), 62);
`ifdef FILTER_SPAD_RANGE_CHK_EN
    chk("inrange.rd_err", 32'(rd_err), 0);
`endif

    $display("test done: total=%0d bad=%0d", n_tot, n_bad);
    $finish;
  end

endmodule
